// File: rtl/jhash_pkg.sv
// Shared constants for the lookup3 (jhash) datapath: word widths,
// per-round rotate amounts and the hash init constant.
package jhash_pkg;

  localparam int JH_W   = 32;
  localparam int JH_SHW = 5;

  // Rotate amounts used by jhash_core, in round order.
  localparam logic [JH_SHW-1:0] JH_ROT0 = 5'd4;
  localparam logic [JH_SHW-1:0] JH_ROT1 = 5'd6;
  localparam logic [JH_SHW-1:0] JH_ROT2 = 5'd8;
  localparam logic [JH_SHW-1:0] JH_ROT3 = 5'd16;
  localparam logic [JH_SHW-1:0] JH_ROT4 = 5'd19;
  localparam logic [JH_SHW-1:0] JH_ROT5 = 5'd4;

  // lookup3 initial value, consumed by jhash_core.
  localparam logic [JH_W-1:0] JH_INIT = 32'hdeadbeef;

endpackage : jhash_pkg

// File: rtl/rotl32.sv
// Combinational 32-bit left rotator built as a 5-level logarithmic
// barrel (rotate by 1, 2, 4, 8, 16 selected by the bits of amt).
module rotl32
  import jhash_pkg::*;
(
  input  logic [JH_W-1:0]   data,
  input  logic [JH_SHW-1:0] amt,
  output logic [JH_W-1:0]   rotated
);

  logic [JH_W-1:0] lvl1;
  logic [JH_W-1:0] lvl2;
  logic [JH_W-1:0] lvl4;
  logic [JH_W-1:0] lvl8;
  logic [JH_W-1:0] lvl16;

  assign lvl1  = amt[0] ? {data[30:0], data[31]}     : data;
  assign lvl2  = amt[1] ? {lvl1[29:0], lvl1[31:30]}  : lvl1;
  assign lvl4  = amt[2] ? {lvl2[27:0], lvl2[31:28]}  : lvl2;
  assign lvl8  = amt[3] ? {lvl4[23:0], lvl4[31:24]}  : lvl4;
  assign lvl16 = amt[4] ? {lvl8[15:0], lvl8[31:16]}  : lvl8;

  assign rotated = lvl16;

endmodule : rotl32

// File: rtl/jhash_mix.sv
// One lookup3 mix step: OA = (a - c) ^ rotl(c, shift), OB = b, OC = c + b.
// REGISTERED selects a purely combinational step or a one-cycle
// registered step with asynchronous active-low clear of the outputs.
module jhash_mix
  import jhash_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [JH_W-1:0]   a,
  input  logic [JH_W-1:0]   b,
  input  logic [JH_W-1:0]   c,
  input  logic [JH_SHW-1:0] shift,
  output logic [JH_W-1:0]   OA,
  output logic [JH_W-1:0]   OB,
  output logic [JH_W-1:0]   OC
);

  logic [JH_W-1:0] diff_p0;
  logic [JH_W-1:0] rot_p0;
  logic [JH_W-1:0] oa_p0;
  logic [JH_W-1:0] ob_p0;
  logic [JH_W-1:0] oc_p0;

  // Stage p0: combinational mix from the raw inputs.
  assign diff_p0 = a - c;

  rotl32 u_rotl32 (
    .data    (c),
    .amt     (shift),
    .rotated (rot_p0)
  );

  assign oa_p0 = diff_p0 ^ rot_p0;
  assign ob_p0 = b;
  assign oc_p0 = c + b;  // uses the incoming c, not the updated a

  generate
    if (REGISTERED) begin : g_reg
      logic [JH_W-1:0] oa_p1;
      logic [JH_W-1:0] ob_p1;
      logic [JH_W-1:0] oc_p1;

      // Stage p1: capture the mix result; reset clears it immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          oa_p1 <= '0;
          ob_p1 <= '0;
          oc_p1 <= '0;
        end else begin
          oa_p1 <= oa_p0;
          ob_p1 <= ob_p0;
          oc_p1 <= oc_p0;
        end
      end

      assign OA = oa_p1;
      assign OB = ob_p1;
      assign OC = oc_p1;
    end else begin : g_comb
      // clk and rst_n are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign OA = oa_p0;
      assign OB = ob_p0;
      assign OC = oc_p0;
    end
  endgenerate

endmodule : jhash_mix

// File: tb/tb_jhash_mix.sv
// Directed bench for jhash_mix: one combinational and one registered
// instance share the same inputs.
module tb_jhash_mix;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b, c;
  logic [4:0]  shift;
  logic [31:0] oa_c, ob_c, oc_c;
  logic [31:0] oa_r, ob_r, oc_r;

  int n_chk;
  int n_err;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  sh;
    logic [31:0] oa;
    logic [31:0] oc;
  } vec_t;

  vec_t vt [5];

  jhash_mix #(.REGISTERED(1'b0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .shift (shift),
    .OA    (oa_c),
    .OB    (ob_c),
    .OC    (oc_c)
  );

  jhash_mix #(.REGISTERED(1'b1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .shift (shift),
    .OA    (oa_r),
    .OB    (ob_r),
    .OC    (oc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    a     = v.a;
    b     = v.b;
    c     = v.c;
    shift = v.sh;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // Hand-computed vectors.
    vt[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000,    5'd4,  32'h0000_0000, 32'h0000_0000};
    vt[1] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003,    5'd4,  32'hFFFF_FFCE, 32'h0000_0005};
    vt[2] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0001,    5'd19, 32'h7FF3_FFFF, 32'h8000_0001};
    vt[3] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0005,    5'd0,  32'h0000_0005, 32'h0000_000C};
    vt[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001,    5'd0,  32'hFFFF_FFFE, 32'h0000_0000};

    // t=0: reset inactive, Basic vector on the inputs.
    rst_n = 1'b1;
    drive(vt[1]);
    #1;
    chk("comb_basic_oa", oa_c, 32'hFFFF_FFCE);
    chk("comb_basic_ob", ob_c, 32'h0000_0002);
    chk("comb_basic_oc", oc_c, 32'h0000_0005);

    // First rising edge at t=5 captures Basic.
    @(posedge clk); #1;
    chk("reg_cap_oa", oa_r, 32'hFFFF_FFCE);
    chk("reg_cap_ob", ob_r, 32'h0000_0002);
    chk("reg_cap_oc", oc_r, 32'h0000_0005);

    // Assert reset mid-cycle (t=7, clock high, no edge until t=10).
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_oa", oa_r, 32'h0);
    chk("async_rst_ob", ob_r, 32'h0);
    chk("async_rst_oc", oc_r, 32'h0);
    chk("comb_in_rst_oa", oa_c, 32'hFFFF_FFCE);

    // Held in reset across clock edges with a new vector applied.
    drive(vt[3]);
    @(posedge clk); #1;
    chk("rst_hold_oa", oa_r, 32'h0);
    chk("rst_hold_oc", oc_r, 32'h0);
    chk("comb_in_rst_oc", oc_c, 32'h0000_000C);

    // Release on a falling edge with Basic applied; nothing until next rise.
    @(negedge clk);
    rst_n = 1'b1;
    drive(vt[1]);
    #1;
    chk("post_rel_oa", oa_r, 32'h0);
    @(posedge clk); #1;
    chk("rel_cap_oa", oa_r, 32'hFFFF_FFCE);
    chk("rel_cap_ob", ob_r, 32'h0000_0002);
    chk("rel_cap_oc", oc_r, 32'h0000_0005);

    // Back-to-back vectors: combinational immediately, registered one cycle later.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("comb_v%0d_oa", i), oa_c, vt[i].oa);
      chk($sformatf("comb_v%0d_ob", i), ob_c, vt[i].b);
      chk($sformatf("comb_v%0d_oc", i), oc_c, vt[i].oc);
      if (i > 0) begin
        chk($sformatf("reg_hold_v%0d_oa", i - 1), oa_r, vt[i-1].oa);
        chk($sformatf("reg_hold_v%0d_oc", i - 1), oc_r, vt[i-1].oc);
      end
      @(posedge clk); #1;
      chk($sformatf("reg_v%0d_oa", i), oa_r, vt[i].oa);
      chk($sformatf("reg_v%0d_ob", i), ob_r, vt[i].b);
      chk($sformatf("reg_v%0d_oc", i), oc_r, vt[i].oc);
    end

    // Rotator sweep on the combinational instance.
    @(negedge clk);
    a = 32'h0;
    b = 32'h0;
    c = 32'h0000_0001;
    for (int s = 0; s < 32; s++) begin
      shift = 5'(s);
      #1;
      chk($sformatf("sweep_s%0d", s), oa_c, 32'hFFFF_FFFF ^ (32'h1 << s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule : tb_jhash_mix
